// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two prioritised write ports and a soft-clear sweep.
// Optional `REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wen0,
    input  logic [ADDR_W-1:0]        i_waddr0,
    input  logic [DATA_W-1:0]        i_wdata0,
    input  logic                     i_wen1,
    input  logic [ADDR_W-1:0]        i_waddr1,
    input  logic [DATA_W-1:0]        i_wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    input  logic                     i_clr_req,
    output logic                     o_clr_busy,
    output logic                     o_wr_ready
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam bit          W_ZERO = (ZERO_REG != 0);

    typedef enum logic {StIdle, StClear} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_wr_en0;
    logic                w_wr_en1;
    logic                w_cnt_last;

    assign o_clr_busy = (r_state == StClear);
    assign o_wr_ready = ~o_clr_busy;
    assign w_cnt_last = (r_cnt == ADDR_W'(DEPTH - 1));

    // Writes to reg 0 are squashed here so both storage and bypass see them as inactive.
    assign w_wr_en0 = i_wen0 & o_wr_ready & ~(W_ZERO & (i_waddr0 == '0));
    assign w_wr_en1 = i_wen1 & o_wr_ready & ~(W_ZERO & (i_waddr1 == '0));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_clr_req) w_state_d = StClear;
            StClear: if (w_cnt_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            if (r_state == StClear) begin
                r_mem[r_cnt] <= '0;
                r_cnt        <= r_cnt + 1'b1;
            end else begin
                // Port 1 is assigned last so it wins an address collision.
                if (w_wr_en0) r_mem[i_waddr0] <= i_wdata0;
                if (w_wr_en1) r_mem[i_waddr1] <= i_wdata1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = i_raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en0 && (i_waddr0 == w_ra)) w_rd = i_wdata0;
            if (w_wr_en1 && (i_waddr1 == w_ra)) w_rd = i_wdata1;
`endif
            if (W_ZERO && (w_ra == '0)) w_rd = '0;
        end

        assign o_rdata[g*DATA_W +: DATA_W] = w_rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected read data is queued from a reference model and popped on read.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        clr_req;
    logic        clr_busy;
    logic        wr_ready;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          errors;
    int          checks;

    regfile_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wen0     (wen0),
        .i_waddr0   (waddr0),
        .i_wdata0   (wdata0),
        .i_wen1     (wen1),
        .i_waddr1   (waddr1),
        .i_wdata1   (wdata1),
        .i_raddr    (raddr),
        .o_rdata    (rdata),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_wr_ready (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        wen0 = e0; waddr0 = a0; wdata0 = d0;
        wen1 = e1; waddr1 = a1; wdata1 = d1;
        cyc();
        wen0 = 1'b0;
        wen1 = 1'b0;
        if (e0 && a0 != 5'd0) model[a0] = d0;
        if (e1 && a1 != 5'd0) model[a1] = d1;
    endtask

    task automatic pop_cmp(input string name, input logic [4:0] a0, input logic [4:0] a1);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rdata[31:0] !== e) begin
            errors++;
            $display("FAIL %s port0 addr=%0d got=%h exp=%h", name, a0, rdata[31:0], e);
        end
        e = exp_q.pop_front();
        checks++;
        if (rdata[63:32] !== e) begin
            errors++;
            $display("FAIL %s port1 addr=%0d got=%h exp=%h", name, a1, rdata[63:32], e);
        end
    endtask

    task automatic rd_check(input string name, input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        exp_q.push_back(model[a0]);
        exp_q.push_back(model[a1]);
        #1;
        pop_cmp(name, a0, a1);
    endtask

    task automatic rd_all(input string name);
        for (int i = 0; i < 32; i += 2) begin
            rd_check(name, 5'(i), 5'(i + 1));
        end
    endtask

    task automatic chk_flags(input string name, input logic busy_exp);
        checks++;
        if (clr_busy !== busy_exp) begin
            errors++;
            $display("FAIL %s clr_busy got=%b exp=%b", name, clr_busy, busy_exp);
        end
        checks++;
        if (wr_ready !== ~busy_exp) begin
            errors++;
            $display("FAIL %s wr_ready got=%b exp=%b", name, wr_ready, ~busy_exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hFFFF_FFFF;
        cyc();
        cyc();
        rst = 1'b1; wen0 = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        chk_flags("reset_flags", 1'b0);
        rd_all("reset_read");
    endtask

    task automatic test_write_read();
        wr(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        rd_check("wr_rd_5", 5'd5, 5'd3);
        wr(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        rd_check("wr_reg0", 5'd0, 5'd5);
        wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5678);
        rd_check("wr1_reg0", 5'd5, 5'd0);
    endtask

    task automatic test_back_to_back();
        wr(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        rd_check("collision_7", 5'd7, 5'd7);
        wr(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd11, 32'h1111_1111);
        wr(1'b1, 5'd31, 32'h3131_3131, 1'b1, 5'd30, 32'h3030_3030);
        rd_check("dual_10_11", 5'd10, 5'd11);
        rd_check("dual_31_30", 5'd31, 5'd30);
    endtask

    task automatic test_sweep();
        int k;
        for (int i = 1; i < 32; i++) wr(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0);
        rd_check("fill", 5'd1, 5'd31);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        k = 0;
        while (clr_busy === 1'b1 && k < 40) begin
            if (k == 3) begin
                wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_wr_ready got=%b exp=0", wr_ready);
                end
                rd_check("sweep_partial", 5'd1, 5'd20);
            end
            if (k == 5) clr_req = 1'b1;
            cyc();
            wen0 = 1'b0;
            clr_req = 1'b0;
            if (k < 32) model[k] = 32'h0;
            k++;
        end
        checks++;
        if (k !== 32) begin
            errors++;
            $display("FAIL sweep_busy_cycles got=%0d exp=32", k);
        end
        chk_flags("sweep_done", 1'b0);
        rd_all("sweep_read");
    endtask

    task automatic test_reset_mid_sweep();
        wr(1'b1, 5'd3, 32'h33, 1'b1, 5'd17, 32'h17);
        wr(1'b1, 5'd25, 32'h25, 1'b0, 5'd0, 32'h0);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            model[k] = 32'h0;
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        chk_flags("midrst_flags", 1'b0);
        rd_all("midrst_read");
        wr(1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 32'h0);
        rd_check("midrst_wr", 5'd12, 5'd17);
    endtask

    task automatic test_bypass();
        logic byp;
`ifdef REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        wr(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'h0);
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h55;
        raddr = {5'd4, 5'd4};
        exp_q.push_back(byp ? 32'h55 : model[4]);
        exp_q.push_back(byp ? 32'h55 : model[4]);
        #1;
        pop_cmp("bypass_same_cycle", 5'd4, 5'd4);
        cyc();
        wen1 = 1'b0;
        model[4] = 32'h55;
        rd_check("bypass_next_cycle", 5'd4, 5'd4);

        wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h77;
        raddr = {5'd0, 5'd0};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        pop_cmp("bypass_reg0", 5'd0, 5'd0);
        cyc();
        wen1 = 1'b0;

        wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h60;
        wen1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h61;
        raddr = {5'd6, 5'd6};
        exp_q.push_back(byp ? 32'h61 : model[6]);
        exp_q.push_back(byp ? 32'h61 : model[6]);
        #1;
        pop_cmp("bypass_priority", 5'd6, 5'd6);
        cyc();
        wen0 = 1'b0;
        wen1 = 1'b0;
        model[6] = 32'h61;
        rd_check("bypass_priority_next", 5'd6, 5'd4);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
        raddr = '0;
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_sweep();
        test_reset_mid_sweep();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
